// File: rtl/regfile_mport.sv
// Multi-read-port register file: NRD read ports, one write port, optional
// write-to-read bypass, optional registered read, optional hardwired-zero
// entry 0, and a sequenced clear sweep that flushes the bank without reset.
//
// Write semantics: a write commits at the rising edge when Wen=1 and the
// clear sweep is not running. There is no handshake; a write offered
// while ClrBusy=1 is dropped and never forwarded to a read port.
module regfile_mport #(
    parameter int WIDTH    = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Wen,
    input  logic [AW-1:0]        Awr,
    input  logic [WIDTH-1:0]     Din,
    input  logic [NRD*AW-1:0]    Ard,
    output logic [NRD*WIDTH-1:0] Dout,
    input  logic                 Clr,
    output logic                 ClrBusy,
    output logic [0:0]           dbg_state,
    output logic [AW-1:0]        dbg_cnt
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] CNT_LAST = '1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SWEEP = 1'b1;

    logic [0:0]       state;
    logic [AW-1:0]    cnt;
    logic             sweeping;
    logic             wr_eff;
    logic [WIDTH-1:0] mem [DEPTH];

    assign sweeping  = (state == S_SWEEP);
    assign ClrBusy   = sweeping;
    assign dbg_state = state;
    assign dbg_cnt   = cnt;

    // A write is dropped during the sweep and, with a hardwired zero entry,
    // when it targets address 0.
    assign wr_eff = Wen && !sweeping && !((ZERO_REG != 0) && (Awr == '0));

    // Clear sequencer: IDLE waits for Clr, SWEEP walks cnt over every entry.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Clr) begin
                        state <= S_SWEEP;
                        cnt   <= '0;
                    end
                end
                S_SWEEP: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Storage: reset zeroes the bank, the sweep zeroes one entry per cycle,
    // otherwise the effective write lands.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (sweeping) begin
            mem[cnt] <= '0;
        end else if (wr_eff) begin
            mem[Awr] <= Din;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NRD; g++) begin : g_rd
            logic [AW-1:0] rd_addr;
            assign rd_addr = Ard[g*AW +: AW];

            if (READ_REG != 0) begin : g_reg
                logic [WIDTH-1:0] nxt_val;
                logic [WIDTH-1:0] rd_q;

                // Value the addressed entry will hold after this edge (write-first).
                always_comb begin
                    nxt_val = mem[rd_addr];
                    if (wr_eff && (Awr == rd_addr)) begin
                        nxt_val = Din;
                    end
                    if (sweeping && (cnt == rd_addr)) begin
                        nxt_val = '0;
                    end
                    if ((ZERO_REG != 0) && (rd_addr == '0)) begin
                        nxt_val = '0;
                    end
                end

                // Registered read data, one-cycle latency.
                always_ff @(posedge Clk or negedge Rst_n) begin
                    if (!Rst_n) begin
                        rd_q <= '0;
                    end else begin
                        rd_q <= nxt_val;
                    end
                end

                assign Dout[g*WIDTH +: WIDTH] = rd_q;
            end else begin : g_comb
                logic [WIDTH-1:0] comb_val;

                // Combinational read; hardwired zero overrides the bypass.
                always_comb begin
                    comb_val = mem[rd_addr];
                    if ((BYPASS != 0) && wr_eff && (Awr == rd_addr)) begin
                        comb_val = Din;
                    end
                    if ((ZERO_REG != 0) && (rd_addr == '0)) begin
                        comb_val = '0;
                    end
                end

                assign Dout[g*WIDTH +: WIDTH] = comb_val;
            end
        end
    endgenerate

endmodule
